// File: rtl/axi_reorder_checker_pkg.sv
// Shared types for the AXI reorder checker: AXI channel structs, the default
// address map, tag bookkeeping types and the response accumulator.
package axi_reorder_checker_pkg;

  localparam int unsigned IdW     = 3;
  localparam int unsigned AddrW   = 32;
  localparam int unsigned DataW   = 32;
  localparam int unsigned MaxTags = 32;

  typedef logic [AddrW-1:0] addr_t;
  typedef logic [$clog2(MaxTags)-1:0] tag_t;

  typedef struct packed {
    logic [31:0] idx;
    addr_t       start_addr;
    addr_t       end_addr;
  } rule_t;

  typedef struct packed { logic [IdW-1:0] id; addr_t addr; } aw_chan_t;
  typedef struct packed { logic [DataW-1:0] data; logic last; } w_chan_t;
  typedef struct packed { logic [IdW-1:0] id; logic [1:0] resp; } b_chan_t;
  typedef struct packed { logic [IdW-1:0] id; addr_t addr; } ar_chan_t;
  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } rsp_t;

  // Element 0 is the first rule checked; end_addr is inclusive.
  localparam rule_t [3:0] DefaultAddrMap = '{
    '{idx: 32'd3, start_addr: 32'h0030_0000, end_addr: 32'h003F_FFFF},
    '{idx: 32'd0, start_addr: 32'h0020_0000, end_addr: 32'h002F_FFFF},
    '{idx: 32'd1, start_addr: 32'h0010_0000, end_addr: 32'h001F_FFFF},
    '{idx: 32'd2, start_addr: 32'h0000_0000, end_addr: 32'h000F_FFFF}
  };

  typedef enum logic [1:0] {TagFree, TagIssued, TagArrived, TagSlvDone} tag_state_e;

  typedef enum logic [2:0] {
    ErrNone, ErrDecode, ErrOverflow, ErrRoute, ErrSpurious, ErrOrder
  } err_kind_e;

  typedef struct packed {
    logic [1:0]       resp;
    logic [15:0]      beats;
    logic [DataW-1:0] fold;
  } acc_t;

  // First non-OKAY response is kept; later beats cannot clear it.
  function automatic acc_t acc_add(acc_t a, logic [1:0] resp, logic [DataW-1:0] data);
    acc_t r;
    r       = a;
    r.resp  = (a.resp != 2'b00) ? a.resp : resp;
    r.beats = a.beats + 16'd1;
    r.fold  = a.fold ^ data;
    return r;
  endfunction

endpackage

// File: rtl/axi_reorder_checker_chan.sv
// One request/response tracker (AW->B or AR->R). Per-ID and per-slave FIFOs are
// realised as "oldest live tag matching the key", ordered by allocation sequence.
module axi_reorder_chan_tracker
  import axi_reorder_checker_pkg::*;
#(
  parameter int unsigned NumSlaves      = 4,
  parameter int unsigned AxiIdWidth     = IdW,
  parameter int unsigned NumAddrRegions = 4,
  parameter int unsigned MaxTxns        = MaxTags,
  parameter rule_t [NumAddrRegions-1:0] AddrRegions = DefaultAddrMap
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 mst_req_vld_i,
  input  logic [AxiIdWidth-1:0]                mst_req_id_i,
  input  logic [AddrW-1:0]                     mst_req_addr_i,
  input  logic [NumSlaves-1:0]                 slv_req_vld_i,
  input  logic [NumSlaves-1:0][AxiIdWidth-1:0] slv_req_id_i,
  input  logic [NumSlaves-1:0]                 slv_rsp_vld_i,
  input  logic [NumSlaves-1:0][AxiIdWidth-1:0] slv_rsp_id_i,
  input  logic [NumSlaves-1:0][1:0]            slv_rsp_resp_i,
  input  logic [NumSlaves-1:0][DataW-1:0]      slv_rsp_data_i,
  input  logic [NumSlaves-1:0]                 slv_rsp_last_i,
  input  logic                                 mst_rsp_vld_i,
  input  logic [AxiIdWidth-1:0]                mst_rsp_id_i,
  input  logic [1:0]                           mst_rsp_resp_i,
  input  logic [DataW-1:0]                     mst_rsp_data_i,
  input  logic                                 mst_rsp_last_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [7:0]                           err_num_o
);

  localparam int unsigned SlvW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;

  tag_state_e            state_q [MaxTxns], state_d [MaxTxns];
  logic [SlvW-1:0]       slv_q   [MaxTxns], slv_d   [MaxTxns];
  logic [AxiIdWidth-1:0] mid_q   [MaxTxns], mid_d   [MaxTxns];
  logic [AxiIdWidth-1:0] sid_q   [MaxTxns], sid_d   [MaxTxns];
  logic [31:0]           seq_q   [MaxTxns], seq_d   [MaxTxns];
  acc_t                  sacc_q  [MaxTxns], sacc_d  [MaxTxns];
  acc_t                  macc_q  [MaxTxns], macc_d  [MaxTxns];
  logic [31:0]           seq_cnt_q, seq_cnt_d;
  logic [7:0]            err_num_q, err_num_d;
  logic                  done_q, done_d;

  logic            dec_hit, free_hit, mrsp_hit;
  logic [SlvW-1:0] dec_slv;
  tag_t            free_tag, mrsp_tag;
  logic [31:0]     mrsp_seq;
  acc_t            macc_new;
  logic            sreq_hit [NumSlaves], srsp_hit [NumSlaves];
  tag_t            sreq_tag [NumSlaves], srsp_tag [NumSlaves];
  logic [31:0]     sreq_seq [NumSlaves], srsp_seq [NumSlaves];

  always_comb begin
    dec_hit = 1'b0;
    dec_slv = '0;
    for (int r = 0; r < NumAddrRegions; r++) begin
      if (!dec_hit && mst_req_addr_i >= AddrRegions[r].start_addr &&
          mst_req_addr_i <= AddrRegions[r].end_addr) begin
        dec_hit = 1'b1;
        dec_slv = SlvW'(AddrRegions[r].idx);
      end
    end
    free_hit = 1'b0;
    free_tag = '0;
    for (int t = 0; t < MaxTxns; t++) begin
      if (!free_hit && state_q[t] == TagFree) begin
        free_hit = 1'b1;
        free_tag = tag_t'(t);
      end
    end
    mrsp_hit = 1'b0;
    mrsp_tag = '0;
    mrsp_seq = '0;
    for (int t = 0; t < MaxTxns; t++) begin
      if (state_q[t] != TagFree && mid_q[t] == mst_rsp_id_i &&
          (!mrsp_hit || seq_q[t] < mrsp_seq)) begin
        mrsp_hit = 1'b1;
        mrsp_tag = tag_t'(t);
        mrsp_seq = seq_q[t];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NumSlaves; s++) begin
      sreq_hit[s] = 1'b0;
      sreq_tag[s] = '0;
      sreq_seq[s] = '0;
      srsp_hit[s] = 1'b0;
      srsp_tag[s] = '0;
      srsp_seq[s] = '0;
      for (int t = 0; t < MaxTxns; t++) begin
        if (state_q[t] == TagIssued && slv_q[t] == SlvW'(s) &&
            (!sreq_hit[s] || seq_q[t] < sreq_seq[s])) begin
          sreq_hit[s] = 1'b1;
          sreq_tag[s] = tag_t'(t);
          sreq_seq[s] = seq_q[t];
        end
        if (state_q[t] == TagArrived && slv_q[t] == SlvW'(s) &&
            sid_q[t] == slv_rsp_id_i[s] && (!srsp_hit[s] || seq_q[t] < srsp_seq[s])) begin
          srsp_hit[s] = 1'b1;
          srsp_tag[s] = tag_t'(t);
          srsp_seq[s] = seq_q[t];
        end
      end
    end
  end

  // All lookups use registered state, so a tag freed this cycle is not reallocated
  // until the next one, and a slave last seen together with the master last fails.
  always_comb begin
    state_d   = state_q;
    slv_d     = slv_q;
    mid_d     = mid_q;
    sid_d     = sid_q;
    seq_d     = seq_q;
    sacc_d    = sacc_q;
    macc_d    = macc_q;
    seq_cnt_d = seq_cnt_q;
    err_num_d = '0;
    done_d    = 1'b0;
    macc_new  = acc_add(macc_q[mrsp_tag], mst_rsp_resp_i, mst_rsp_data_i);

    if (mst_req_vld_i) begin
      if (!dec_hit || !free_hit) begin
        err_num_d = err_num_d + 8'd1;
      end else begin
        state_d[free_tag] = TagIssued;
        slv_d[free_tag]   = dec_slv;
        mid_d[free_tag]   = mst_req_id_i;
        seq_d[free_tag]   = seq_cnt_q;
        sacc_d[free_tag]  = '0;
        macc_d[free_tag]  = '0;
        seq_cnt_d         = seq_cnt_q + 32'd1;
      end
    end

    for (int s = 0; s < NumSlaves; s++) begin
      if (slv_req_vld_i[s]) begin
        if (!sreq_hit[s]) begin
          err_num_d = err_num_d + 8'd1;
        end else begin
          state_d[sreq_tag[s]] = TagArrived;
          sid_d[sreq_tag[s]]   = slv_req_id_i[s];
        end
      end
      if (slv_rsp_vld_i[s]) begin
        if (!srsp_hit[s]) begin
          err_num_d = err_num_d + 8'd1;
        end else begin
          sacc_d[srsp_tag[s]] = acc_add(sacc_q[srsp_tag[s]], slv_rsp_resp_i[s],
                                        slv_rsp_data_i[s]);
          if (slv_rsp_last_i[s]) state_d[srsp_tag[s]] = TagSlvDone;
        end
      end
    end

    if (mst_rsp_vld_i) begin
      if (!mrsp_hit) begin
        err_num_d = err_num_d + 8'd1;
      end else if (mst_rsp_last_i) begin
        done_d = 1'b1;
        if (state_q[mrsp_tag] != TagSlvDone || macc_new != sacc_q[mrsp_tag]) begin
          err_num_d = err_num_d + 8'd1;
        end
        state_d[mrsp_tag] = TagFree;
      end else begin
        macc_d[mrsp_tag] = macc_new;
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int t = 0; t < MaxTxns; t++) busy_o = busy_o | (state_q[t] != TagFree);
  end

  assign done_o    = done_q;
  assign err_num_o = err_num_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int t = 0; t < MaxTxns; t++) state_q[t] <= TagFree;
      seq_cnt_q <= '0;
      err_num_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_cnt_q <= seq_cnt_d;
      err_num_q <= err_num_d;
      done_q    <= done_d;
    end
  end

  // Payload arrays are only read for live tags, which allocation initialises.
  always_ff @(posedge clk_i) begin
    slv_q  <= slv_d;
    mid_q  <= mid_d;
    sid_q  <= sid_d;
    seq_q  <= seq_d;
    sacc_q <= sacc_d;
    macc_q <= macc_d;
  end

endmodule

// File: rtl/axi_reorder_checker.sv
// Passive scoreboard for a response-reordering AXI network interface: one write
// and one read tracker, a saturating error counter and the end-of-sim detector.
module axi_reorder_checker
  import axi_reorder_checker_pkg::*;
#(
  parameter int unsigned NumSlaves      = 4,
  parameter int unsigned AxiIdWidth     = IdW,
  parameter int unsigned NumAddrRegions = 4,
  parameter int unsigned MaxTxns        = MaxTags,
  parameter int unsigned IdleCycles     = 100,
  parameter rule_t [NumAddrRegions-1:0] AddrRegions = DefaultAddrMap
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  req_t                 mon_mst_req_i,
  input  rsp_t                 mon_mst_rsp_i,
  input  req_t [NumSlaves-1:0] mon_slv_req_i,
  input  rsp_t [NumSlaves-1:0] mon_slv_rsp_i,
  output logic                 end_of_sim_o,
  output logic                 error_o,
  output logic [31:0]          err_cnt_o
);

  logic [NumSlaves-1:0]                 aw_vld, ar_vld, b_vld, r_vld, b_last, r_last;
  logic [NumSlaves-1:0][AxiIdWidth-1:0] aw_id, ar_id, b_id, r_id;
  logic [NumSlaves-1:0][1:0]            b_resp, r_resp;
  logic [NumSlaves-1:0][DataW-1:0]      b_data, r_data;
  logic                                 unused_fields;

  always_comb begin
    unused_fields = ^{mon_mst_req_i.w, mon_mst_req_i.w_valid, mon_mst_rsp_i.w_ready};
    for (int s = 0; s < NumSlaves; s++) begin
      aw_vld[s] = mon_slv_req_i[s].aw_valid & mon_slv_rsp_i[s].aw_ready;
      ar_vld[s] = mon_slv_req_i[s].ar_valid & mon_slv_rsp_i[s].ar_ready;
      b_vld[s]  = mon_slv_rsp_i[s].b_valid & mon_slv_req_i[s].b_ready;
      r_vld[s]  = mon_slv_rsp_i[s].r_valid & mon_slv_req_i[s].r_ready;
      aw_id[s]  = mon_slv_req_i[s].aw.id;
      ar_id[s]  = mon_slv_req_i[s].ar.id;
      b_id[s]   = mon_slv_rsp_i[s].b.id;
      r_id[s]   = mon_slv_rsp_i[s].r.id;
      b_resp[s] = mon_slv_rsp_i[s].b.resp;
      r_resp[s] = mon_slv_rsp_i[s].r.resp;
      b_data[s] = '0;
      r_data[s] = mon_slv_rsp_i[s].r.data;
      b_last[s] = 1'b1;
      r_last[s] = mon_slv_rsp_i[s].r.last;
      unused_fields = unused_fields ^ ^{mon_slv_req_i[s].w, mon_slv_req_i[s].w_valid,
                                        mon_slv_rsp_i[s].w_ready, mon_slv_req_i[s].aw.addr,
                                        mon_slv_req_i[s].ar.addr};
    end
  end

  logic       wr_busy, rd_busy, wr_done, rd_done;
  logic [7:0] wr_err, rd_err;

  axi_reorder_chan_tracker #(
    .NumSlaves(NumSlaves), .AxiIdWidth(AxiIdWidth), .NumAddrRegions(NumAddrRegions),
    .MaxTxns(MaxTxns), .AddrRegions(AddrRegions)
  ) i_wr (
    .clk_i, .rst_ni,
    .mst_req_vld_i  (mon_mst_req_i.aw_valid & mon_mst_rsp_i.aw_ready),
    .mst_req_id_i   (mon_mst_req_i.aw.id),
    .mst_req_addr_i (mon_mst_req_i.aw.addr),
    .slv_req_vld_i  (aw_vld),
    .slv_req_id_i   (aw_id),
    .slv_rsp_vld_i  (b_vld),
    .slv_rsp_id_i   (b_id),
    .slv_rsp_resp_i (b_resp),
    .slv_rsp_data_i (b_data),
    .slv_rsp_last_i (b_last),
    .mst_rsp_vld_i  (mon_mst_rsp_i.b_valid & mon_mst_req_i.b_ready),
    .mst_rsp_id_i   (mon_mst_rsp_i.b.id),
    .mst_rsp_resp_i (mon_mst_rsp_i.b.resp),
    .mst_rsp_data_i ('0),
    .mst_rsp_last_i (1'b1),
    .busy_o         (wr_busy),
    .done_o         (wr_done),
    .err_num_o      (wr_err)
  );

  axi_reorder_chan_tracker #(
    .NumSlaves(NumSlaves), .AxiIdWidth(AxiIdWidth), .NumAddrRegions(NumAddrRegions),
    .MaxTxns(MaxTxns), .AddrRegions(AddrRegions)
  ) i_rd (
    .clk_i, .rst_ni,
    .mst_req_vld_i  (mon_mst_req_i.ar_valid & mon_mst_rsp_i.ar_ready),
    .mst_req_id_i   (mon_mst_req_i.ar.id),
    .mst_req_addr_i (mon_mst_req_i.ar.addr),
    .slv_req_vld_i  (ar_vld),
    .slv_req_id_i   (ar_id),
    .slv_rsp_vld_i  (r_vld),
    .slv_rsp_id_i   (r_id),
    .slv_rsp_resp_i (r_resp),
    .slv_rsp_data_i (r_data),
    .slv_rsp_last_i (r_last),
    .mst_rsp_vld_i  (mon_mst_rsp_i.r_valid & mon_mst_req_i.r_ready),
    .mst_rsp_id_i   (mon_mst_rsp_i.r.id),
    .mst_rsp_resp_i (mon_mst_rsp_i.r.resp),
    .mst_rsp_data_i (mon_mst_rsp_i.r.data),
    .mst_rsp_last_i (mon_mst_rsp_i.r.last),
    .busy_o         (rd_busy),
    .done_o         (rd_done),
    .err_num_o      (rd_err)
  );

  logic [31:0] err_cnt_q, err_cnt_d, idle_cnt_q, idle_cnt_d;
  logic        error_q, error_d, seen_q, seen_d, eos_q, eos_d;
  logic [32:0] err_sum;

  always_comb begin
    err_sum    = {1'b0, err_cnt_q} + 33'(wr_err) + 33'(rd_err);
    err_cnt_d  = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    error_d    = error_q | (wr_err != 8'd0) | (rd_err != 8'd0);
    seen_d     = seen_q | wr_done | rd_done;
    idle_cnt_d = idle_cnt_q;
    if (wr_busy || rd_busy)           idle_cnt_d = '0;
    else if (idle_cnt_q < IdleCycles) idle_cnt_d = idle_cnt_q + 32'd1;
    eos_d      = eos_q | (seen_q && idle_cnt_q >= IdleCycles);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_q  <= '0;
      error_q    <= 1'b0;
      seen_q     <= 1'b0;
      idle_cnt_q <= '0;
      eos_q      <= 1'b0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      error_q    <= error_d;
      seen_q     <= seen_d;
      idle_cnt_q <= idle_cnt_d;
      eos_q      <= eos_d;
    end
  end

  assign err_cnt_o    = err_cnt_q;
  assign error_o      = error_q;
  assign end_of_sim_o = eos_q;

endmodule

// File: tb/tb_axi_reorder_checker.sv
// Directed bench for axi_reorder_checker: one scenario per block, each starting
// from reset, with hand-computed error counts and end-of-sim expectations.
module tb_axi_reorder_checker;
  import axi_reorder_checker_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  req_t        mreq;
  rsp_t        mrsp;
  req_t [3:0]  sreq;
  rsp_t [3:0]  srsp;
  logic        eos, err;
  logic [31:0] cnt;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  axi_reorder_checker dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mon_mst_req_i(mreq), .mon_mst_rsp_i(mrsp),
    .mon_slv_req_i(sreq), .mon_slv_rsp_i(srsp),
    .end_of_sim_o(eos), .error_o(err), .err_cnt_o(cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mreq.aw_valid = 1'b0; mreq.ar_valid = 1'b0; mreq.w_valid = 1'b0;
    mrsp.b_valid  = 1'b0; mrsp.r_valid  = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sreq[s].aw_valid = 1'b0; sreq[s].ar_valid = 1'b0; sreq[s].w_valid = 1'b0;
      srsp[s].b_valid  = 1'b0; srsp[s].r_valid  = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic mst_aw(input logic [2:0] id, input logic [31:0] a);
    mreq.aw.id = id; mreq.aw.addr = a; mreq.aw_valid = 1'b1; tick();
  endtask
  task automatic mst_ar(input logic [2:0] id, input logic [31:0] a);
    mreq.ar.id = id; mreq.ar.addr = a; mreq.ar_valid = 1'b1; tick();
  endtask
  task automatic slv_aw(input int s, input logic [2:0] id);
    sreq[s].aw.id = id; sreq[s].aw.addr = '0; sreq[s].aw_valid = 1'b1; tick();
  endtask
  task automatic slv_ar(input int s, input logic [2:0] id);
    sreq[s].ar.id = id; sreq[s].ar.addr = '0; sreq[s].ar_valid = 1'b1; tick();
  endtask
  task automatic set_slv_b(input int s, input logic [2:0] id, input logic [1:0] resp);
    srsp[s].b.id = id; srsp[s].b.resp = resp; srsp[s].b_valid = 1'b1;
  endtask
  task automatic set_mst_b(input logic [2:0] id, input logic [1:0] resp);
    mrsp.b.id = id; mrsp.b.resp = resp; mrsp.b_valid = 1'b1;
  endtask
  task automatic set_slv_r(input int s, input logic [2:0] id, input logic [31:0] d,
                           input logic last);
    srsp[s].r.id = id; srsp[s].r.data = d; srsp[s].r.resp = 2'b00;
    srsp[s].r.last = last; srsp[s].r_valid = 1'b1;
  endtask
  task automatic set_mst_r(input logic [2:0] id, input logic [31:0] d, input logic last);
    mrsp.r.id = id; mrsp.r.data = d; mrsp.r.resp = 2'b00;
    mrsp.r.last = last; mrsp.r_valid = 1'b1;
  endtask

  task automatic wait_eos(input string tag);
    int k;
    k = 0;
    while (eos !== 1'b1 && k < 300) begin tick(); k++; end
    chk(tag, 32'(eos), 32'd1);
  endtask

  initial begin
    mreq = '0; mrsp = '0; sreq = '0; srsp = '0;
    mrsp.aw_ready = 1'b1; mrsp.ar_ready = 1'b1; mrsp.w_ready = 1'b1;
    mreq.b_ready  = 1'b1; mreq.r_ready  = 1'b1;
    for (int s = 0; s < 4; s++) begin
      srsp[s].aw_ready = 1'b1; srsp[s].ar_ready = 1'b1; srsp[s].w_ready = 1'b1;
      sreq[s].b_ready  = 1'b1; sreq[s].r_ready  = 1'b1;
    end

    do_reset();
    chk("reset_eos", 32'(eos), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_cnt", cnt, 32'd0);

    // single write to slave 1
    mst_aw(3'd2, 32'h0012_0010);
    slv_aw(1, 3'd2);
    set_slv_b(1, 3'd2, 2'b00); tick();
    set_mst_b(3'd2, 2'b00); tick();
    tick();
    chk("write_cnt", cnt, 32'd0);
    repeat (50) tick();
    chk("write_eos_early", 32'(eos), 32'd0);
    wait_eos("write_eos");

    // reordered reads, correct delivery order
    do_reset();
    mst_ar(3'd1, 32'h0000_0100);
    mst_ar(3'd1, 32'h0021_0000);
    slv_ar(2, 3'd1);
    slv_ar(0, 3'd1);
    set_slv_r(0, 3'd1, 32'hAAAA_0000, 1'b1); tick();
    set_slv_r(2, 3'd1, 32'h1234_5678, 1'b1); tick();
    set_mst_r(3'd1, 32'h1234_5678, 1'b1); tick();
    set_mst_r(3'd1, 32'hAAAA_0000, 1'b1); tick();
    tick();
    chk("reorder_ok_cnt", cnt, 32'd0);

    // fast slave's data delivered first
    do_reset();
    mst_ar(3'd1, 32'h0000_0100);
    mst_ar(3'd1, 32'h0021_0000);
    slv_ar(2, 3'd1);
    slv_ar(0, 3'd1);
    set_slv_r(0, 3'd1, 32'hAAAA_0000, 1'b1); tick();
    set_slv_r(2, 3'd1, 32'h1234_5678, 1'b1); tick();
    set_mst_r(3'd1, 32'hAAAA_0000, 1'b1); tick();
    tick();
    chk("reorder_bad_cnt", cnt, 32'd1);

    // payload corruption on beat 3
    do_reset();
    mst_ar(3'd3, 32'h0010_0000);
    slv_ar(1, 3'd3);
    for (int b = 0; b < 4; b++) begin
      set_slv_r(1, 3'd3, 32'h0000_1000 + 32'(b), b == 3); tick();
    end
    for (int b = 0; b < 4; b++) begin
      set_mst_r(3'd3, (32'h0000_1000 + 32'(b)) ^ ((b == 3) ? 32'd1 : 32'd0), b == 3); tick();
    end
    chk("corrupt_err_lag", 32'(err), 32'd0);
    tick();
    chk("corrupt_err", 32'(err), 32'd1);
    chk("corrupt_cnt", cnt, 32'd1);

    // wrong route: decoded to slave 0, seen on slave 3
    do_reset();
    mst_aw(3'd0, 32'h0021_0000);
    slv_aw(3, 3'd0);
    tick();
    chk("route_cnt", cnt, 32'd1);

    // unmapped address, then a clean read must still drain
    do_reset();
    mst_ar(3'd0, 32'h0040_0000);
    tick();
    chk("decode_cnt", cnt, 32'd1);
    mst_ar(3'd0, 32'h0010_0040);
    slv_ar(1, 3'd0);
    set_slv_r(1, 3'd0, 32'hCAFE_0001, 1'b1); tick();
    set_mst_r(3'd0, 32'hCAFE_0001, 1'b1); tick();
    tick();
    chk("decode_clean_cnt", cnt, 32'd1);
    wait_eos("decode_eos");

    // spurious responses on both channels in one cycle
    do_reset();
    set_slv_r(0, 3'd4, 32'h5, 1'b1);
    set_mst_b(3'd6, 2'b00);
    tick();
    tick();
    chk("spurious_cnt", cnt, 32'd2);

    // slave last and master last on the same tag in the same cycle
    do_reset();
    mst_ar(3'd2, 32'h0030_0000);
    slv_ar(3, 3'd2);
    set_slv_r(3, 3'd2, 32'h77, 1'b1);
    set_mst_r(3'd2, 32'h77, 1'b1);
    tick();
    tick();
    chk("same_cycle_cnt", cnt, 32'd1);

    // capacity, overflow, then a one-cycle reset
    do_reset();
    for (int k = 0; k < 32; k++) mst_aw(3'(k), 32'h0012_0000 + 32'(k) * 32'h10);
    tick();
    chk("cap_full_cnt", cnt, 32'd0);
    mst_aw(3'd7, 32'h0012_1000);
    tick();
    chk("overflow_cnt", cnt, 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_eos", 32'(eos), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    mst_aw(3'd5, 32'h0030_0000);
    slv_aw(3, 3'd5);
    set_slv_b(3, 3'd5, 2'b00); tick();
    set_mst_b(3'd5, 2'b00); tick();
    tick();
    chk("post_rst_cnt", cnt, 32'd0);
    wait_eos("post_rst_eos");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
